// File: rtl/dma_write_cmd_sched_pkg.sv
// rtl/dma_write_cmd_sched_pkg.sv - shared widths, defaults and FSM encoding for the DMA write command scheduler
package dma_write_cmd_sched_pkg;

    localparam int ADDR_W  = 64;
    localparam int LEN_W   = 32;
    localparam int ENTRY_W = ADDR_W + LEN_W;

    localparam logic [LEN_W-1:0] DEFAULT_MAX_CHUNK = 32'h007F_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage

// File: rtl/dma_write_cmd_sched_fifo.sv
// rtl/dma_write_cmd_sched_fifo.sv - synchronous command FIFO with registered full/empty flags
module dma_cmd_fifo
    import dma_write_cmd_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] pop_data,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic [PTR_W:0]     count_next;
    logic               do_push;
    logic               do_pop;

    // Gating with the flags lets push and pop coexist in one cycle safely.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == DEPTH_CNT);
            empty <= (count_next == '0);
        end
    end

    // Entry storage; contents need no reset because empty guards reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dma_write_cmd_sched.sv
// rtl/dma_write_cmd_sched.sv - splits queued write commands into bounded chunks for the S2MM write controller
module dma_write_cmd_sched
    import dma_write_cmd_sched_pkg::*;
#(
    parameter int               FIFO_DEPTH = 4,
    parameter logic [LEN_W-1:0] MAX_CHUNK  = DEFAULT_MAX_CHUNK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              wr_start,
    output logic [ADDR_W-1:0] wr_dest_addr,
    output logic [LEN_W-1:0]  wr_byte_num,
    input  logic              wr_done,
    output logic              busy,
    output logic              cmd_done,
    output logic [15:0]       done_cnt,
    output logic              err_zero_len
);

    state_t             state;
    state_t             state_next;
    logic [ENTRY_W-1:0] head;
    logic [ADDR_W-1:0]  head_addr;
    logic [LEN_W-1:0]   head_len;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [ADDR_W-1:0]  cur_addr;
    logic [LEN_W-1:0]   remaining;
    logic [LEN_W-1:0]   remaining_next;
    logic [LEN_W-1:0]   chunk;
    logic               wd_q;
    logic               wd_rise;

    assign cmd_ready = !fifo_full;

    dma_cmd_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data ({cmd_addr, cmd_len}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_addr = head[ENTRY_W-1:LEN_W];
    assign head_len  = head[LEN_W-1:0];

    // wr_byte_num holds the chunk in flight, so completion retires exactly that amount.
    assign chunk          = (remaining > MAX_CHUNK) ? MAX_CHUNK : remaining;
    assign remaining_next = remaining - wr_byte_num;
    assign wd_rise        = wr_done && !wd_q;
    assign busy           = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Next-state and FIFO pop decode.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE:  if (!fifo_empty) state_next = ST_LOAD;
            ST_LOAD: begin
                pop        = 1'b1;
                state_next = (head_len == '0) ? ST_IDLE : ST_ISSUE;
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (wd_rise) state_next = (remaining_next == '0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP:   state_next = ST_ISSUE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Command datapath, downstream request registers and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q         <= 1'b0;
            cur_addr     <= '0;
            remaining    <= '0;
            wr_start     <= 1'b0;
            wr_dest_addr <= '0;
            wr_byte_num  <= '0;
            cmd_done     <= 1'b0;
            done_cnt     <= '0;
            err_zero_len <= 1'b0;
        end else begin
            wd_q         <= wr_done;
            wr_start     <= 1'b0;
            cmd_done     <= 1'b0;
            err_zero_len <= 1'b0;
            case (state)
                ST_LOAD: begin
                    cur_addr     <= head_addr;
                    remaining    <= head_len;
                    err_zero_len <= (head_len == '0);
                end
                ST_ISSUE: begin
                    wr_dest_addr <= cur_addr;
                    wr_byte_num  <= chunk;
                    wr_start     <= 1'b1;
                end
                ST_WAIT: begin
                    if (wd_rise) begin
                        cur_addr  <= cur_addr + {{(ADDR_W-LEN_W){1'b0}}, wr_byte_num};
                        remaining <= remaining_next;
                        if (remaining_next == '0) begin
                            cmd_done <= 1'b1;
                            done_cnt <= done_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_write_cmd_sched.sv
// tb/tb_dma_write_cmd_sched.sv - self-checking bench for dma_write_cmd_sched
module tb_dma_write_cmd_sched;

    localparam int          FIFO_DEPTH = 4;
    localparam logic [31:0] MAXC       = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_addr = '0;
    logic [31:0] cmd_len = '0;
    logic        wr_start;
    logic [63:0] wr_dest_addr;
    logic [31:0] wr_byte_num;
    logic        wr_done;
    logic        busy;
    logic        cmd_done;
    logic [15:0] done_cnt;
    logic        err_zero_len;

    logic wd_auto = 1'b0;
    logic wd_man  = 1'b0;
    assign wr_done = wd_auto | wd_man;

    always #5 clk = ~clk;

    dma_write_cmd_sched #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .MAX_CHUNK (MAXC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .wr_start     (wr_start),
        .wr_dest_addr (wr_dest_addr),
        .wr_byte_num  (wr_byte_num),
        .wr_done      (wr_done),
        .busy         (busy),
        .cmd_done     (cmd_done),
        .done_cnt     (done_cnt),
        .err_zero_len (err_zero_len)
    );

    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
        bit          last;
        bit          zero;
    } item_t;

    item_t       exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    bit          waiting = 0;
    bit          cur_last = 0;
    logic [15:0] exp_done = '0;
    int          since_start = 100;
    logic [63:0] last_a = '0;
    logic [31:0] last_l = '0;
    int          n_start = 0;
    int          n_err = 0;
    logic [1:0]  wd_s = 2'b00;
    bit          rise;
    bit          exp_cd;
    bit          auto_en = 1;
    int          resp_dly = 3;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Expand one accepted command into the transfers the scheduler owes.
    function automatic void model_push(input logic [63:0] a, input logic [31:0] l);
        logic [63:0] addr = a;
        logic [31:0] rem = l;
        logic [31:0] c;
        if (l == 0) begin
            exp_q.push_back('{addr: a, len: 32'd0, last: 1'b0, zero: 1'b1});
        end else begin
            while (rem != 0) begin
                c = (rem > MAXC) ? MAXC : rem;
                exp_q.push_back('{addr: addr, len: c, last: (c == rem), zero: 1'b0});
                addr = addr + 64'(c);
                rem  = rem - c;
            end
        end
    endfunction

    // wr_done as the DUT samples it on each rising edge.
    always @(posedge clk) wd_s <= {wd_s[0], wr_done};

    // Compare process: every cycle, against the transfer-list model.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            waiting     = 0;
            exp_done    = '0;
            since_start = 100;
            last_a      = '0;
            last_l      = '0;
            chk("rst_wr_start", wr_start, 0);
            chk("rst_cmd_done", cmd_done, 0);
            chk("rst_err_zero", err_zero_len, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done_cnt", done_cnt, 0);
            chk("rst_dest", wr_dest_addr, 0);
            chk("rst_num", wr_byte_num, 0);
            chk("rst_ready", cmd_ready, 1);
        end else begin
            rise   = wd_s[0] && !wd_s[1];
            exp_cd = 0;
            if (waiting && rise) begin
                exp_cd  = cur_last;
                if (cur_last) exp_done = exp_done + 16'd1;
                waiting = 0;
            end
            chk("cmd_done", cmd_done, exp_cd);
            chk("done_cnt", done_cnt, exp_done);
            if (wr_start) begin
                n_start++;
                chk("start_while_waiting", waiting, 0);
                chk("start_spacing", since_start >= 2, 1);
                if (exp_q.size() == 0) begin
                    chk("start_expected", 0, 1);
                end else begin
                    chk("start_not_zero_cmd", exp_q[0].zero, 0);
                    chk("wr_dest_addr", wr_dest_addr, exp_q[0].addr);
                    chk("wr_byte_num", wr_byte_num, exp_q[0].len);
                    cur_last = exp_q[0].last;
                    void'(exp_q.pop_front());
                end
                waiting     = 1;
                since_start = 0;
                last_a      = wr_dest_addr;
                last_l      = wr_byte_num;
            end else begin
                chk("dest_hold", wr_dest_addr, last_a);
                chk("num_hold", wr_byte_num, last_l);
            end
            if (err_zero_len) begin
                n_err++;
                chk("zero_expected", (exp_q.size() > 0) && exp_q[0].zero, 1);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (waiting) chk("busy_wait", busy, 1);
            if (cmd_valid && cmd_ready) model_push(cmd_addr, cmd_len);
            since_start++;
        end
    end

    // Write-controller stand-in: one-cycle completion pulse resp_dly cycles after each start.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_en && wr_start) begin
                repeat (resp_dly) @(posedge clk);
                #1 wd_auto = 1'b1;
                @(posedge clk);
                #1 wd_auto = 1'b0;
            end
        end
    end

    task automatic push_cmd(input logic [63:0] a, input logic [31:0] l);
        int n = 0;
        bit ok = 0;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        while (!ok && n < 400) begin
            @(negedge clk);
            ok = cmd_ready;
            n++;
        end
        chk("push_accept", ok, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        bit found = 0;
        while (!found && n < 50) begin
            @(negedge clk);
            found = wr_start;
            n++;
        end
        chk(name, found, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int lim);
        int n = 0;
        bit done = 0;
        while (!done && n < lim) begin
            @(posedge clk);
            #2;
            done = (exp_q.size() == 0) && !waiting && !busy;
            n++;
        end
        chk(name, done, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int k;
        bit found;
        int s0;
        int e0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Single command that exactly fills one chunk, with start latency.
        push_cmd(64'h1_0000_1000, 32'h100);
        k = 0;
        found = 0;
        while (!found && k < 10) begin
            @(negedge clk);
            k++;
            found = wr_start;
        end
        chk("t1_latency", k, 4);
        chk("t1_addr", wr_dest_addr, 64'h1_0000_1000);
        chk("t1_len", wr_byte_num, 32'h100);
        @(posedge clk);
        #1;
        wait_idle("t1_idle", 100);
        chk("t1_done_cnt", done_cnt, 1);

        // Split into three chunks.
        s0 = n_start;
        push_cmd(64'h2000, 32'h250);
        wait_idle("t2_idle", 200);
        chk("t2_starts", n_start - s0, 3);
        chk("t2_last_addr", wr_dest_addr, 64'h2200);
        chk("t2_last_len", wr_byte_num, 32'h50);
        chk("t2_done_cnt", done_cnt, 2);

        // Zero-length command discarded, next one runs normally.
        s0 = n_start;
        e0 = n_err;
        push_cmd(64'h3000, 32'h0);
        push_cmd(64'h3100, 32'h10);
        wait_idle("t3_idle", 200);
        chk("t3_errs", n_err - e0, 1);
        chk("t3_starts", n_start - s0, 1);
        chk("t3_addr", wr_dest_addr, 64'h3100);
        chk("t3_done_cnt", done_cnt, 3);

        // wr_done already high before ISSUE: only a fresh rising edge completes.
        auto_en = 0;
        wd_man  = 1'b1;
        push_cmd(64'h5000, 32'h40);
        wait_start("t4_start");
        repeat (6) @(posedge clk);
        #1;
        chk("t4_held_busy", busy, 1);
        chk("t4_held_no_done", done_cnt, 3);
        wd_man = 1'b0;
        @(posedge clk);
        #1 wd_man = 1'b1;
        @(posedge clk);
        #1 wd_man = 1'b0;
        wait_idle("t4_idle", 50);
        chk("t4_done_cnt", done_cnt, 4);
        auto_en = 1;

        // Address wraps past 2^64 between chunks.
        push_cmd(64'hFFFF_FFFF_FFFF_FF80, 32'h180);
        wait_idle("t5_idle", 200);
        chk("t5_wrap_addr", wr_dest_addr, 64'h80);
        chk("t5_wrap_len", wr_byte_num, 32'h80);
        chk("t5_done_cnt", done_cnt, 5);

        // Back-pressure: one command in flight plus four stored fills the FIFO.
        do_reset();
        resp_dly = 30;
        s0 = n_start;
        push_cmd(64'hA000, 32'h20);
        wait_start("t6_first_start");
        for (int i = 1; i <= 4; i++) push_cmd(64'hA000 + 64'(i) * 64'h1000, 32'(i) * 32'h10);
        @(negedge clk);
        chk("t6_ready_low", cmd_ready, 0);
        @(posedge clk);
        #1;
        wait_idle("t6_idle", 600);
        chk("t6_starts", n_start - s0, 5);
        chk("t6_done_cnt", done_cnt, 5);
        chk("t6_ready_back", cmd_ready, 1);

        // Reset while waiting with two queued commands.
        resp_dly = 40;
        push_cmd(64'h9000, 32'h40);
        wait_start("t7_start");
        push_cmd(64'h9100, 32'h10);
        push_cmd(64'h9200, 32'h10);
        do_reset();
        s0 = n_start;
        repeat (60) @(posedge clk);
        #2;
        chk("t7_no_start", n_start - s0, 0);
        chk("t7_busy", busy, 0);
        chk("t7_ready", cmd_ready, 1);
        chk("t7_done_cnt", done_cnt, 0);
        chk("t7_dest", wr_dest_addr, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
